// File: rtl/tpu_pkg.sv
// Shared TPU types and default widths for the activation control path.
// Activation codes, instruction field widths and the accumulator-to-activation latency.
package tpu_pkg;

  localparam int ACC_ADDR_WIDTH_DEF = 9;
  localparam int BUF_ADDR_WIDTH_DEF = 24;
  localparam int LEN_WIDTH_DEF      = 32;
  localparam int PIPE_DELAY_DEF     = 4;

  typedef enum logic [1:0] {
    no_activation = 2'd0,
    relu          = 2'd1,
    sigmoid       = 2'd2,
    tanh_act      = 2'd3
  } activation_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/valid_addr_delay.sv
// Fixed-depth shift register carrying a valid bit and an address alongside it.
// pending reports valid entries still upstream of the output stage.
module valid_addr_delay #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_addr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_addr,
  output logic             pending
);

  logic [DEPTH-1:0] valid_sr;
  logic [WIDTH-1:0] addr_sr [DEPTH];

  // Shift valid and address one stage per cycle; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_sr[i] <= {WIDTH{1'b0}};
      end
    end else begin
      valid_sr[0] <= in_valid;
      addr_sr[0]  <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        addr_sr[i]  <= addr_sr[i-1];
      end
    end
  end

  // Any valid entry in the stages before the output one.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending = pending | valid_sr[i];
    end
  end

  assign out_valid = valid_sr[DEPTH-1];
  assign out_addr  = addr_sr[DEPTH-1];

endmodule

// File: rtl/activation_control.sv
// Sequences one activation instruction: streams accumulator reads, then
// drains the activation pipeline into delayed unified-buffer writes.
module activation_control
  import tpu_pkg::*;
#(
  parameter int ACC_ADDR_WIDTH = ACC_ADDR_WIDTH_DEF,
  parameter int BUF_ADDR_WIDTH = BUF_ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH      = LEN_WIDTH_DEF,
  parameter int PIPE_DELAY     = PIPE_DELAY_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_en,
  input  logic [ACC_ADDR_WIDTH-1:0] instr_acc_addr,
  input  logic [BUF_ADDR_WIDTH-1:0] instr_buf_addr,
  input  logic [LEN_WIDTH-1:0]      instr_length,
  input  activation_type            instr_act,
  input  logic                      instr_signed,
  output logic                      busy,
  output logic                      resource_busy,
  output logic [ACC_ADDR_WIDTH-1:0] acc_read_addr,
  output logic                      act_enable,
  output activation_type            act_function,
  output logic                      act_signed,
  output logic [BUF_ADDR_WIDTH-1:0] buf_write_addr,
  output logic                      buf_write_en
);

  ctrl_state_t               state;
  logic [LEN_WIDTH-1:0]      remaining;
  logic [BUF_ADDR_WIDTH-1:0] buf_addr;
  logic                      pending;

  // Control FSM; every output it drives is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      resource_busy <= 1'b0;
      act_enable    <= 1'b0;
      acc_read_addr <= {ACC_ADDR_WIDTH{1'b0}};
      act_function  <= no_activation;
      act_signed    <= 1'b0;
      remaining     <= {LEN_WIDTH{1'b0}};
      buf_addr      <= {BUF_ADDR_WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (instr_en && (instr_length != {LEN_WIDTH{1'b0}})) begin
            state         <= READ;
            busy          <= 1'b1;
            resource_busy <= 1'b1;
            act_enable    <= 1'b1;
            acc_read_addr <= instr_acc_addr;
            buf_addr      <= instr_buf_addr;
            remaining     <= instr_length;
            act_function  <= instr_act;
            act_signed    <= instr_signed;
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          // buf_addr feeds the delay line alongside this cycle's read.
          buf_addr <= buf_addr + BUF_ADDR_WIDTH'(1);
          if (remaining == LEN_WIDTH'(1)) begin
            state         <= DRAIN;
            resource_busy <= 1'b0;
          end else begin
            remaining     <= remaining - LEN_WIDTH'(1);
            acc_read_addr <= acc_read_addr + ACC_ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          // Output stage holds the final write when nothing is left upstream.
          if (buf_write_en && !pending) begin
            state      <= IDLE;
            busy       <= 1'b0;
            act_enable <= 1'b0;
          end else begin
            state <= DRAIN;
          end
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          resource_busy <= 1'b0;
          act_enable    <= 1'b0;
        end
      endcase
    end
  end

  valid_addr_delay #(
    .WIDTH(BUF_ADDR_WIDTH),
    .DEPTH(PIPE_DELAY)
  ) u_write_delay (
    .clk      (clk),
    .rst      (rst),
    .in_valid (resource_busy),
    .in_addr  (buf_addr),
    .out_valid(buf_write_en),
    .out_addr (buf_write_addr),
    .pending  (pending)
  );

endmodule

// File: tb/tb_activation_control.sv
// Self-checking bench for activation_control: directed scenarios plus random
// traffic, all compared against a per-instruction timing model.
module tb_activation_control;
  import tpu_pkg::*;

  localparam int PD = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           instr_en = 1'b0;
  logic [8:0]     instr_acc_addr = 9'd0;
  logic [23:0]    instr_buf_addr = 24'd0;
  logic [31:0]    instr_length = 32'd0;
  activation_type instr_act = no_activation;
  logic           instr_signed = 1'b0;
  logic           busy, resource_busy, act_enable, act_signed, buf_write_en;
  logic [8:0]     acc_read_addr;
  logic [23:0]    buf_write_addr;
  activation_type act_function;

  int checks = 0;
  int errors = 0;

  activation_control #(
    .ACC_ADDR_WIDTH(9), .BUF_ADDR_WIDTH(24), .LEN_WIDTH(32), .PIPE_DELAY(PD)
  ) dut (
    .clk(clk), .rst(rst), .instr_en(instr_en),
    .instr_acc_addr(instr_acc_addr), .instr_buf_addr(instr_buf_addr),
    .instr_length(instr_length), .instr_act(instr_act), .instr_signed(instr_signed),
    .busy(busy), .resource_busy(resource_busy), .acc_read_addr(acc_read_addr),
    .act_enable(act_enable), .act_function(act_function), .act_signed(act_signed),
    .buf_write_addr(buf_write_addr), .buf_write_en(buf_write_en)
  );

  always #5 clk = ~clk;

  // Model: the last accepted instruction and the cycle of its first read.
  longint         cyc = 0;
  bit             m_has = 1'b0;
  longint         m_start = 0;
  longint         m_len = 0;
  logic [8:0]     m_acc = 9'd0;
  logic [23:0]    m_buf = 24'd0;
  activation_type m_act = no_activation;
  logic           m_sgn = 1'b0;

  function automatic logic [39:0] exp_vec(input longint c);
    longint rel;
    logic b, rb, we;
    logic [8:0] a;
    logic [23:0] wa;
    activation_type f;
    logic s;
    b = 1'b0; rb = 1'b0; we = 1'b0; a = 9'd0; wa = 24'd0; f = no_activation; s = 1'b0;
    if (m_has) begin
      rel = c - m_start;
      b   = (rel >= 0) && (rel < m_len + PD);
      rb  = (rel >= 0) && (rel < m_len);
      a   = (rel < m_len) ? m_acc + 9'(rel) : m_acc + 9'(m_len - 1);
      we  = (rel >= PD) && (rel < PD + m_len);
      if (we) wa = m_buf + 24'(rel - PD);
      f = m_act;
      s = m_sgn;
    end
    return {b, rb, b, a, we, wa, f, s};
  endfunction

  function automatic logic [39:0] obs_vec();
    return {busy, resource_busy, act_enable, acc_read_addr, buf_write_en,
            (buf_write_en ? buf_write_addr : 24'd0), act_function, act_signed};
  endfunction

  always @(posedge clk) begin
    logic [39:0] ev;
    ev = exp_vec(cyc);
    cyc = cyc + 1;
    if (rst) begin
      m_has = 1'b0;
    end else if (instr_en && instr_length != 32'd0 && !ev[39]) begin
      m_has = 1'b1; m_start = cyc; m_len = longint'(instr_length);
      m_acc = instr_acc_addr; m_buf = instr_buf_addr; m_act = instr_act; m_sgn = instr_signed;
    end
  end

  task automatic set_instr(input logic en, input logic [8:0] a, input logic [23:0] b,
                           input logic [31:0] l, input activation_type f, input logic s);
    instr_en = en; instr_acc_addr = a; instr_buf_addr = b;
    instr_length = l; instr_act = f; instr_signed = s;
  endtask

  task automatic test_reset();
    logic [39:0] ov;
    rst = 1'b1;
    set_instr(1'b1, 9'd9, 24'd9, 32'd5, relu, 1'b1);
    repeat (3) @(negedge clk);
    ov = obs_vec();
    checks++;
    if (ov !== 40'd0) begin errors++; $display("FAIL reset_values: got %h expected %h", ov, 40'd0); end
    rst = 1'b0;
    set_instr(1'b0, 9'd0, 24'd0, 32'd0, no_activation, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_priority: busy got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    logic [39:0] ev, ov;
    logic [8:0] rq[$];
    logic [23:0] wq[$];
    int rc[$], wc[$];
    int fall = -1, bad_act = 0;
    set_instr(1'b1, 9'd5, 24'd100, 32'd3, relu, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      ev = exp_vec(cyc); ov = obs_vec(); checks++;
      if (ov !== ev) begin errors++; $display("FAIL basic_model @%0d: got %h expected %h", k, ov, ev); end
      instr_en = 1'b0;
      if (resource_busy) begin rq.push_back(acc_read_addr); rc.push_back(k); end
      if (buf_write_en) begin wq.push_back(buf_write_addr); wc.push_back(k); end
      if (busy === 1'b0 && fall < 0) fall = k;
      if (busy === 1'b1 && (act_function !== relu || act_signed !== 1'b1)) bad_act++;
    end
    checks++;
    if (rq.size() != 3 || wq.size() != 3) begin
      errors++; $display("FAIL basic_counts: reads %0d writes %0d expected 3 and 3", rq.size(), wq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rq[i] !== 9'(5 + i) || rc[i] != i + 1 || wq[i] !== 24'(100 + i) || wc[i] != i + 5) begin
          errors++;
          $display("FAIL basic_seq[%0d]: read %0d@%0d write %0d@%0d expected %0d@%0d %0d@%0d",
                   i, rq[i], rc[i], wq[i], wc[i], 5 + i, i + 1, 100 + i, i + 5);
        end
      end
    end
    checks++;
    if (fall != 8) begin errors++; $display("FAIL basic_busy_fall: got %0d expected 8", fall); end
    checks++;
    if (bad_act != 0) begin errors++; $display("FAIL basic_act: %0d bad cycles expected 0", bad_act); end
  endtask

  task automatic test_zero_length();
    logic [39:0] ev, ov;
    int nb = 0, nw = 0;
    set_instr(1'b1, 9'd7, 24'd7, 32'd0, sigmoid, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ev = exp_vec(cyc); ov = obs_vec(); checks++;
      if (ov !== ev) begin errors++; $display("FAIL zero_model @%0d: got %h expected %h", k, ov, ev); end
      if (busy !== 1'b0) nb++;
      if (buf_write_en !== 1'b0) nw++;
    end
    instr_en = 1'b0;
    checks++;
    if (nb != 0 || nw != 0) begin errors++; $display("FAIL zero_length: busy %0d writes %0d expected 0 and 0", nb, nw); end
  endtask

  task automatic test_busy_reject();
    logic [39:0] ev, ov;
    int n50 = 0, nw = 0;
    set_instr(1'b1, 9'd20, 24'd200, 32'd4, sigmoid, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      ev = exp_vec(cyc); ov = obs_vec(); checks++;
      if (ov !== ev) begin errors++; $display("FAIL reject_model @%0d: got %h expected %h", k, ov, ev); end
      if (resource_busy && acc_read_addr == 9'd50) n50++;
      if (buf_write_en) nw++;
      if (k <= 5) set_instr(1'b1, 9'd50, 24'd300, 32'd6, relu, 1'b1);
      else instr_en = 1'b0;
    end
    checks++;
    if (n50 != 0 || nw != 4) begin errors++; $display("FAIL busy_reject: reads@50 %0d writes %0d expected 0 and 4", n50, nw); end
  endtask

  task automatic test_wrap();
    logic [39:0] ev, ov;
    logic [8:0] rq[$];
    logic [23:0] wq[$];
    set_instr(1'b1, 9'd511, 24'hFFFFFF, 32'd2, tanh_act, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      ev = exp_vec(cyc); ov = obs_vec(); checks++;
      if (ov !== ev) begin errors++; $display("FAIL wrap_model @%0d: got %h expected %h", k, ov, ev); end
      instr_en = 1'b0;
      if (resource_busy) rq.push_back(acc_read_addr);
      if (buf_write_en) wq.push_back(buf_write_addr);
    end
    checks++;
    if (rq.size() != 2 || wq.size() != 2) begin
      errors++; $display("FAIL wrap_counts: reads %0d writes %0d expected 2 and 2", rq.size(), wq.size());
    end else if (rq[0] !== 9'd511 || rq[1] !== 9'd0 || wq[0] !== 24'hFFFFFF || wq[1] !== 24'd0) begin
      errors++; $display("FAIL wrap_addrs: reads %0d,%0d writes %h,%h expected 511,0 ffffff,000000", rq[0], rq[1], wq[0], wq[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [39:0] ev, ov;
    int nw = 0;
    set_instr(1'b1, 9'd3, 24'd40, 32'd10, relu, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      ev = exp_vec(cyc); ov = obs_vec(); checks++;
      if (ov !== ev) begin errors++; $display("FAIL rstmid_model @%0d: got %h expected %h", k, ov, ev); end
      instr_en = 1'b0;
      if (k >= 3 && buf_write_en !== 1'b0) nw++;
      if (k == 2) rst = 1'b1;
      if (k == 3) begin
        checks++;
        if (ov !== 40'd0) begin errors++; $display("FAIL rstmid_values: got %h expected %h", ov, 40'd0); end
        rst = 1'b0;
      end
    end
    checks++;
    if (nw != 0) begin errors++; $display("FAIL rstmid_writes: got %0d expected 0", nw); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] ev, ov;
    bit fell = 1'b0;
    int nw = 0;
    logic [23:0] wq[$];
    set_instr(1'b1, 9'd60, 24'd500, 32'd2, relu, 1'b1);
    for (int k = 1; k <= 20 && !fell; k++) begin
      @(negedge clk);
      ev = exp_vec(cyc); ov = obs_vec(); checks++;
      if (ov !== ev) begin errors++; $display("FAIL b2b_model @%0d: got %h expected %h", k, ov, ev); end
      instr_en = 1'b0;
      if (k > 1 && busy === 1'b0) fell = 1'b1;
    end
    checks++;
    if (!fell) begin errors++; $display("FAIL b2b_timeout: busy got 1 expected fall within 20 cycles"); end
    set_instr(1'b1, 9'd30, 24'd600, 32'd2, sigmoid, 1'b0);
    @(negedge clk);
    instr_en = 1'b0;
    checks++;
    if (resource_busy !== 1'b1 || acc_read_addr !== 9'd30 || act_function !== sigmoid || act_signed !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_read: rb %b addr %0d fn %0d sgn %b expected 1 30 %0d 0",
               resource_busy, acc_read_addr, act_function, act_signed, sigmoid);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ev = exp_vec(cyc); ov = obs_vec(); checks++;
      if (ov !== ev) begin errors++; $display("FAIL b2b_model2 @%0d: got %h expected %h", k, ov, ev); end
      if (buf_write_en) begin nw++; wq.push_back(buf_write_addr); end
    end
    checks++;
    if (nw != 2 || wq[0] !== 24'd600 || wq[1] !== 24'd601) begin
      errors++; $display("FAIL b2b_writes: count %0d expected 2 at 600,601", nw);
    end
  endtask

  task automatic test_random();
    logic [39:0] ev, ov;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      ev = exp_vec(cyc); ov = obs_vec(); checks++;
      if (ov !== ev) begin errors++; $display("FAIL random_model @%0d: got %h expected %h", k, ov, ev); end
      rst = ($urandom_range(0, 99) < 2);
      set_instr(($urandom_range(0, 99) < 30), 9'($urandom), 24'($urandom),
                ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 20)),
                activation_type'($urandom_range(0, 3)), 1'($urandom));
    end
    rst = 1'b0;
    instr_en = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_busy_reject();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/activation_control.md
ACTIVATION_CONTROL -- requirements
Module: activation_control

Interface
REQ-001 SHALL have parameter ACC_ADDR_WIDTH, default 9, meaning the accumulator read address width.
REQ-002 SHALL have parameter BUF_ADDR_WIDTH, default 24, meaning the unified buffer write address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 32, meaning the calc_length field width.
REQ-004 SHALL have parameter PIPE_DELAY, default 4, meaning the cycles from an accumulator read address to a valid activation output (1 accumulator read plus 3 activation).
REQ-005 SHALL use the decided clocking: reset rst, synchronous, active-high; clock clk.
REQ-006 SHALL have these ports:
  - clk  in  1  clock.
  - rst  in  1  synchronous active-high reset.
  - instr_en  in  1  instruction valid.
  - instr_acc_addr  in  ACC_ADDR_WIDTH  first accumulator row.
  - instr_buf_addr  in  BUF_ADDR_WIDTH  first buffer row.
  - instr_length  in  LEN_WIDTH  row count.
  - instr_act  in  activation_type  activation function.
  - instr_signed  in  1  signed data.
  - busy  out  1  instruction in flight.
  - resource_busy  out  1  accumulator read phase active.
  - acc_read_addr  out  ACC_ADDR_WIDTH  accumulator read address.
  - act_enable  out  1  activation pipeline enable.
  - act_function  out  activation_type  to the activation unit.
  - act_signed  out  1  to the activation unit.
  - buf_write_addr  out  BUF_ADDR_WIDTH  buffer write address.
  - buf_write_en  out  1  buffer write strobe.

Function
REQ-007 SHALL implement states IDLE, READ and DRAIN.
REQ-008 In IDLE, instr_en=1 with instr_length>0 SHALL latch all instruction fields and enter READ on the next edge; instr_length=0 SHALL be ignored.
REQ-009 instr_en while busy=1 SHALL be ignored with no effect on the running instruction.
REQ-010 In READ, acc_read_addr SHALL equal latched acc_addr+k on the k-th READ cycle, k=0..length-1, modulo 2^ACC_ADDR_WIDTH.
REQ-011 After the length-th READ cycle the block SHALL enter DRAIN and hold acc_read_addr at its last value.
REQ-012 A read issued in cycle t SHALL produce buf_write_en=1 in cycle t+PIPE_DELAY with buf_write_addr=buf_addr+k, modulo 2^BUF_ADDR_WIDTH.
REQ-013 Exactly length write strobes SHALL occur per instruction, with no gaps and no duplicates.
REQ-014 DRAIN SHALL return to IDLE in the cycle after the last write strobe.
REQ-015 busy SHALL be 1 from the first READ cycle through the last write cycle inclusive, and 0 otherwise.
REQ-016 resource_busy SHALL be 1 exactly during READ cycles.
REQ-017 act_enable SHALL be 1 whenever busy=1, and 0 otherwise.
REQ-018 act_function and act_signed SHALL be driven from the latched fields throughout busy, and hold their last values in IDLE.
REQ-019 The total latency from instruction accept to busy falling SHALL be length+PIPE_DELAY+1 cycles.
REQ-020 The write-side valid and write-address pipeline SHALL be a PIPE_DELAY-deep shift register; no counter SHALL assume a fixed latency.
REQ-021 The length counter SHALL be LEN_WIDTH wide; length=2^LEN_WIDTH-1 SHALL complete without overflow.

Reset
REQ-022 rst SHALL force the IDLE state and the outputs busy=0, resource_busy=0, act_enable=0, buf_write_en=0, acc_read_addr=0, buf_write_addr=0, act_function=no_activation and act_signed=0.
REQ-023 rst SHALL flush every delay-line stage.
REQ-024 rst asserted mid-instruction SHALL drop all pending writes, and no buf_write_en SHALL appear after rst.
REQ-025 rst SHALL take priority over instr_en in the same cycle.

Structure
REQ-026 activation_type, the instruction field widths and PIPE_DELAY's default SHALL live in tpu_pkg.
REQ-027 The write-side delay line SHALL be the sub-module valid_addr_delay (parameters WIDTH and DEPTH), instantiated once.

Verification
REQ-028 Scenario 1 SHALL check a basic instruction: acc=5, buf=100, length=3, relu, signed=1 -> acc_read_addr 5,6,7 on cycles 1-3; writes to 100,101,102 on cycles 5-7; busy falls at cycle 8; act_function=relu throughout.
REQ-029 Scenario 2 SHALL check a zero-length instruction: length=0 -> busy stays 0 and no writes occur.
REQ-030 Scenario 3 SHALL check busy rejection: a second instr_en during busy (acc=50) -> no read of address 50 and the write count equals the first length.
REQ-031 Scenario 4 SHALL check address wrap-around: acc=511, buf=2^24-1, length=2 -> reads 511,0 and writes 2^24-1,0.
REQ-032 Scenario 5 SHALL check reset mid-operation: rst in the 2nd READ cycle of a length=10 instruction -> all outputs at reset values next cycle, and zero writes afterwards.
REQ-033 Scenario 6 SHALL check back-to-back instructions: a new instr_en in the cycle busy falls is accepted -> its first read occurs one cycle later and its sigmoid/unsigned settings apply.
